// File: rtl/branch_tag_allocator.sv
// Branch tag allocator: hands out the 2-bit branch IDs that index the BTB in
// ring order, retires them oldest-first, and squashes every tag younger than
// a mispredicted branch so stale BTB entries are never consumed.
//
// Allocation handshake: decode raises alloc_req_i and may hold it; a tag is
// taken at the rising edge only in a cycle where alloc_gnt_o is high, and
// alloc_id_o names that tag. A low grant simply means "try again next cycle".
module branch_tag_allocator #(
    parameter int N_TAG  = 4,
    parameter int W_BRID = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [W_BRID-1:0] alloc_id_o,
    input  logic              resolve_v_i,
    input  logic [W_BRID-1:0] resolve_id_i,
    input  logic              mispredict_i,
    output logic              retire_v_o,
    output logic [W_BRID-1:0] retire_id_o,
    output logic              flush_v_o,
    output logic [N_TAG-1:0]  flush_mask_o,
    output logic [W_BRID:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [W_BRID-1:0] r_head;
    logic [W_BRID-1:0] r_tail;
    logic [W_BRID:0]   r_count;
    logic [N_TAG-1:0]  r_live;
    logic [N_TAG-1:0]  r_done;
    logic              r_flush_v;
    logic [N_TAG-1:0]  r_flush_mask;

    logic              w_full;
    logic              w_empty;
    logic              w_res_acc;
    logic              w_mp;
    logic              w_gnt;
    logic              w_retire;
    logic [N_TAG-1:0]  w_young;
    logic [W_BRID:0]   w_n_young;
    logic [W_BRID:0]   w_count_nxt;
    logic [W_BRID-1:0] w_tail_nxt;
    logic [W_BRID-1:0] w_head_nxt;
    logic [N_TAG-1:0]  w_live_nxt;
    logic [N_TAG-1:0]  w_done_nxt;

    // Full/empty come from the registered count, so a same-cycle retire
    // never opens a slot for a grant.
    assign w_full  = (r_count == (W_BRID+1)'(N_TAG));
    assign w_empty = (r_count == '0);

    // A resolve only counts for a live, not-yet-resolved tag; anything else
    // (including its mispredict flag) is dropped.
    assign w_res_acc = resolve_v_i & r_live[resolve_id_i] & ~r_done[resolve_id_i];
    assign w_mp      = w_res_acc & mispredict_i;
    assign w_gnt     = alloc_req_i & ~w_full & ~w_mp;
    assign w_retire  = r_live[r_head] & r_done[r_head];

    // Younger-than-X set: live tags whose distance from head exceeds X's.
    // Live tags always form one contiguous run starting at head.
    always_comb begin
        logic [W_BRID-1:0] v_off_x;
        logic [W_BRID-1:0] v_off_i;
        v_off_x   = resolve_id_i - r_head;
        v_off_i   = '0;
        w_young   = '0;
        w_n_young = '0;
        for (int i = 0; i < N_TAG; i++) begin
            v_off_i = W_BRID'(i) - r_head;
            if (r_live[i] && (v_off_i > v_off_x)) begin
                w_young[i] = 1'b1;
            end
            w_n_young = w_n_young + (W_BRID+1)'(w_young[i]);
        end
    end

    // Next-state for pointers, count and per-tag live/done bits.
    always_comb begin
        w_live_nxt = r_live;
        w_done_nxt = r_done;
        if (w_retire) begin
            w_live_nxt[r_head] = 1'b0;
        end
        if (w_gnt) begin
            w_live_nxt[r_tail] = 1'b1;
            w_done_nxt[r_tail] = 1'b0;
        end
        if (w_res_acc) begin
            w_done_nxt[resolve_id_i] = 1'b1;
        end
        if (w_mp) begin
            w_live_nxt = w_live_nxt & ~w_young;
            w_done_nxt = w_done_nxt & ~w_young;
        end

        w_head_nxt = w_retire ? (r_head + W_BRID'(1)) : r_head;
        if (w_mp) begin
            w_tail_nxt = resolve_id_i + W_BRID'(1);
        end else if (w_gnt) begin
            w_tail_nxt = r_tail + W_BRID'(1);
        end else begin
            w_tail_nxt = r_tail;
        end

        w_count_nxt = r_count + (W_BRID+1)'(w_gnt) - (W_BRID+1)'(w_retire)
                      - (w_mp ? w_n_young : '0);
    end

    // State registers; reset clears everything with no flush or retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_live       <= '0;
            r_done       <= '0;
            r_flush_v    <= 1'b0;
            r_flush_mask <= '0;
        end else begin
            r_head       <= w_head_nxt;
            r_tail       <= w_tail_nxt;
            r_count      <= w_count_nxt;
            r_live       <= w_live_nxt;
            r_done       <= w_done_nxt;
            r_flush_v    <= w_mp;
            r_flush_mask <= w_mp ? w_young : '0;
        end
    end

    assign alloc_gnt_o  = w_gnt;
    assign alloc_id_o   = r_tail;
    assign retire_v_o   = w_retire;
    assign retire_id_o  = r_head;
    assign flush_v_o    = r_flush_v;
    assign flush_mask_o = r_flush_mask;
    assign count_o      = r_count;
    assign full_o       = w_full;
    assign empty_o      = w_empty;

endmodule

// File: tb/tb_branch_tag_allocator.sv
// Bench for branch_tag_allocator: scenario tasks drive stimulus and check
// inline; expected retire IDs are queued when a resolve is driven and popped
// by a monitor whenever the DUT signals a retire.
module tb_branch_tag_allocator;
    localparam int N_TAG  = 4;
    localparam int W_BRID = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_req_i;
    logic              alloc_gnt_o;
    logic [W_BRID-1:0] alloc_id_o;
    logic              resolve_v_i;
    logic [W_BRID-1:0] resolve_id_i;
    logic              mispredict_i;
    logic              retire_v_o;
    logic [W_BRID-1:0] retire_id_o;
    logic              flush_v_o;
    logic [N_TAG-1:0]  flush_mask_o;
    logic [W_BRID:0]   count_o;
    logic              full_o;
    logic              empty_o;

    int checks = 0;
    int errors = 0;
    logic [W_BRID-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    branch_tag_allocator #(.N_TAG(N_TAG), .W_BRID(W_BRID)) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req_i  (alloc_req_i),
        .alloc_gnt_o  (alloc_gnt_o),
        .alloc_id_o   (alloc_id_o),
        .resolve_v_i  (resolve_v_i),
        .resolve_id_i (resolve_id_i),
        .mispredict_i (mispredict_i),
        .retire_v_o   (retire_v_o),
        .retire_id_o  (retire_id_o),
        .flush_v_o    (flush_v_o),
        .flush_mask_o (flush_mask_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    // scoreboard: every retire must match the oldest expected ID
    always @(negedge clk) begin
        if (reset === 1'b0 && retire_v_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected got id %0d expected none", retire_id_o);
            end else begin
                logic [W_BRID-1:0] e;
                e = exp_q.pop_front();
                if (retire_id_o !== e) begin
                    errors++;
                    $display("FAIL retire_id got %0d expected %0d", retire_id_o, e);
                end
            end
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req_i  = 1'b0;
        resolve_v_i  = 1'b0;
        resolve_id_i = '0;
        mispredict_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        alloc_req_i = 1'b1;
        repeat (n) next_cycle();
        alloc_req_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({alloc_id_o, retire_id_o} !== '0) begin
            errors++;
            $display("FAIL reset_ids got alloc %0d retire %0d expected 0 0", alloc_id_o, retire_id_o);
        end
        checks++;
        if ({empty_o, full_o, retire_v_o, alloc_gnt_o, flush_v_o} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got e%b f%b r%b g%b fl%b expected e1 f0 r0 g0 fl0",
                     empty_o, full_o, retire_v_o, alloc_gnt_o, flush_v_o);
        end
        checks++;
        if (count_o !== 3'd0 || flush_mask_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_count got count %0d mask %b expected 0 0000", count_o, flush_mask_o);
        end
        next_cycle();
    endtask

    task automatic test_basic_alloc();
        alloc_req_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (alloc_gnt_o !== (k < 4) || alloc_id_o !== W_BRID'(k % 4)) begin
                errors++;
                $display("FAIL alloc_%0d got gnt %b id %0d expected gnt %b id %0d",
                         k, alloc_gnt_o, alloc_id_o, (k < 4), k % 4);
            end
            next_cycle();
        end
        alloc_req_i = 1'b0;
        @(negedge clk);
        checks++;
        if (count_o !== 3'd4 || full_o !== 1'b1 || empty_o !== 1'b0) begin
            errors++;
            $display("FAIL alloc_full got count %0d full %b empty %b expected 4 1 0", count_o, full_o, empty_o);
        end
        next_cycle();
    endtask

    task automatic test_retire_wrap();
        resolve_v_i  = 1'b1;
        resolve_id_i = 2'd0;
        exp_q.push_back(2'd0);
        next_cycle();
        resolve_v_i = 1'b0;
        alloc_req_i = 1'b1;
        @(negedge clk);
        checks++;
        if (retire_v_o !== 1'b1 || retire_id_o !== 2'd0 || count_o !== 3'd4) begin
            errors++;
            $display("FAIL retire_vis got v %b id %0d count %0d expected 1 0 4", retire_v_o, retire_id_o, count_o);
        end
        checks++;
        if (alloc_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL full_retire_gnt got %b expected 0", alloc_gnt_o);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (count_o !== 3'd3 || alloc_gnt_o !== 1'b1 || alloc_id_o !== 2'd0) begin
            errors++;
            $display("FAIL wrap_grant got count %0d gnt %b id %0d expected 3 1 0", count_o, alloc_gnt_o, alloc_id_o);
        end
        next_cycle();
        alloc_req_i = 1'b0;
    endtask

    // expects live 1,2,3,0 with head 1, none resolved
    task automatic test_mispredict_squash();
        resolve_v_i  = 1'b1;
        resolve_id_i = 2'd2;
        mispredict_i = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (flush_v_o !== 1'b1 || flush_mask_o !== 4'b1001) begin
            errors++;
            $display("FAIL squash_flush got v %b mask %b expected 1 1001", flush_v_o, flush_mask_o);
        end
        checks++;
        if (count_o !== 3'd2 || alloc_id_o !== 2'd3) begin
            errors++;
            $display("FAIL squash_state got count %0d tail %0d expected 2 3", count_o, alloc_id_o);
        end
        next_cycle();
        alloc_req_i = 1'b1;
        @(negedge clk);
        checks++;
        if (flush_v_o !== 1'b0 || flush_mask_o !== 4'b0000) begin
            errors++;
            $display("FAIL squash_pulse got v %b mask %b expected 0 0000", flush_v_o, flush_mask_o);
        end
        checks++;
        if (alloc_gnt_o !== 1'b1 || alloc_id_o !== 2'd3) begin
            errors++;
            $display("FAIL squash_regrant got gnt %b id %0d expected 1 3", alloc_gnt_o, alloc_id_o);
        end
        next_cycle();
        alloc_req_i  = 1'b0;
        resolve_v_i  = 1'b1;
        resolve_id_i = 2'd1;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        next_cycle();
        resolve_v_i = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (count_o !== 3'd1 || retire_v_o !== 1'b0 || retire_id_o !== 2'd3) begin
            errors++;
            $display("FAIL squash_drain got count %0d rv %b head %0d expected 1 0 3", count_o, retire_v_o, retire_id_o);
        end
        next_cycle();
    endtask

    task automatic test_out_of_order();
        do_reset();
        alloc_n(4);
        resolve_v_i  = 1'b1;
        resolve_id_i = 2'd2;
        next_cycle();
        resolve_id_i = 2'd1;
        @(negedge clk);
        checks++;
        if (retire_v_o !== 1'b0) begin
            errors++;
            $display("FAIL ooo_hold_a got %b expected 0", retire_v_o);
        end
        next_cycle();
        resolve_id_i = 2'd0;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        @(negedge clk);
        checks++;
        if (retire_v_o !== 1'b0) begin
            errors++;
            $display("FAIL ooo_hold_b got %b expected 0", retire_v_o);
        end
        next_cycle();
        resolve_v_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (retire_v_o !== 1'b1 || retire_id_o !== W_BRID'(k)) begin
                errors++;
                $display("FAIL ooo_retire_%0d got v %b id %0d expected 1 %0d", k, retire_v_o, retire_id_o, k);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (retire_v_o !== 1'b0 || count_o !== 3'd1 || retire_id_o !== 2'd3) begin
            errors++;
            $display("FAIL ooo_remain got v %b count %0d head %0d expected 0 1 3", retire_v_o, count_o, retire_id_o);
        end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        alloc_n(3);
        alloc_req_i  = 1'b1;
        resolve_v_i  = 1'b1;
        resolve_id_i = 2'd0;
        mispredict_i = 1'b1;
        exp_q.push_back(2'd0);
        @(negedge clk);
        checks++;
        if (alloc_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL sim_gnt got %b expected 0", alloc_gnt_o);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (flush_v_o !== 1'b1 || flush_mask_o !== 4'b0110 || count_o !== 3'd1 || alloc_id_o !== 2'd1) begin
            errors++;
            $display("FAIL sim_flush got v %b mask %b count %0d tail %0d expected 1 0110 1 1",
                     flush_v_o, flush_mask_o, count_o, alloc_id_o);
        end
        checks++;
        if (retire_v_o !== 1'b1 || retire_id_o !== 2'd0) begin
            errors++;
            $display("FAIL sim_retire got v %b id %0d expected 1 0", retire_v_o, retire_id_o);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (empty_o !== 1'b1 || count_o !== 3'd0 || flush_v_o !== 1'b0) begin
            errors++;
            $display("FAIL sim_empty got empty %b count %0d flush %b expected 1 0 0", empty_o, count_o, flush_v_o);
        end
        next_cycle();
    endtask

    // starts empty with head = tail = 1
    task automatic test_illegal_and_reset();
        resolve_v_i  = 1'b1;
        resolve_id_i = 2'($urandom_range(0, 3));
        mispredict_i = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (flush_v_o !== 1'b0 || count_o !== 3'd0 || alloc_id_o !== 2'd1 || retire_v_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal_resolve got flush %b count %0d tail %0d rv %b expected 0 0 1 0",
                     flush_v_o, count_o, alloc_id_o, retire_v_o);
        end
        next_cycle();
        alloc_n(4);
        @(negedge clk);
        checks++;
        if (full_o !== 1'b1 || alloc_id_o !== 2'd1) begin
            errors++;
            $display("FAIL refill got full %b tail %0d expected 1 1", full_o, alloc_id_o);
        end
        next_cycle();
        resolve_v_i  = 1'b1;
        resolve_id_i = 2'd2;
        mispredict_i = 1'b1;
        reset        = 1'b1;
        @(negedge clk);
        checks++;
        if (empty_o !== 1'b1 || alloc_id_o !== 2'd0 || flush_v_o !== 1'b0 || retire_v_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got empty %b tail %0d flush %b rv %b expected 1 0 0 0",
                     empty_o, alloc_id_o, flush_v_o, retire_v_o);
        end
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (flush_v_o !== 1'b0 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL post_reset got flush %b count %0d expected 0 0", flush_v_o, count_o);
        end
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        test_reset();
        test_basic_alloc();
        test_retire_wrap();
        repeat ($urandom_range(0, 3)) next_cycle();
        test_mispredict_squash();
        test_out_of_order();
        test_simultaneous();
        test_illegal_and_reset();
        // final report
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL retire_leftover got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_tag_allocator.md
# branch_tag_allocator

Allocates, tracks and retires the 2-bit branch IDs that index the branch target buffer. It sits between decode, which requests a tag for each predicted branch, and the branch unit, which resolves branches. It hands out tags in ring order and retires them oldest-first. On a misprediction it squashes every tag younger than the mispredicted branch, so stale BTB entries are never consumed.

## Interface
- `N_TAG`, 4: number of tags; must equal 2**W_BRID.
- `W_BRID`, 2: tag width, matching the BTB `pred_id`/`branch_id` width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `alloc_req_i`  in  1  decode requests a tag this cycle.
- `alloc_gnt_o`  out  1  tag granted this cycle (combinational).
- `alloc_id_o`  out  W_BRID  tag granted; equals tail pointer.
- `resolve_v_i`  in  1  branch unit resolves a branch.
- `resolve_id_i`  in  W_BRID  tag being resolved.
- `mispredict_i`  in  1  qualifies `resolve_v_i`: the branch was mispredicted.
- `retire_v_o`  out  1  head tag is resolved and retires at this edge.
- `retire_id_o`  out  W_BRID  head pointer.
- `flush_v_o`  out  1  registered one-cycle pulse after an accepted mispredict.
- `flush_mask_o`  out  N_TAG  registered; bit i set = tag i was squashed.
- `count_o`  out  W_BRID+1  live tags, 0..N_TAG.
- `full_o`, `empty_o`  out  1  `count_o == N_TAG` / `count_o == 0`.

## Operation
- State: `head_r`, `tail_r` (W_BRID, wrap mod N_TAG), `count_r`, `live_r[N_TAG]`, `done_r[N_TAG]`, `flush_v_r`, `flush_mask_r`.
- Reset: all pointers, `count_r`, `live_r`, `done_r`, `flush_v_r` and `flush_mask_r` are 0. Outputs after reset: `alloc_id_o`=0, `retire_id_o`=0, `empty_o`=1, all others 0.
- Resolve is accepted only when `live_r[resolve_id_i]` is set and `done_r[resolve_id_i]` is clear. Any other resolve is ignored entirely, including its mispredict.
- Mispredict event: `mp = resolve accepted & mispredict_i`.
- Grant: `alloc_gnt_o = alloc_req_i & ~full_o & ~mp`. A grant sets `live[tail]`, clears `done[tail]`, and advances tail by 1 with wrap.
- Accepted resolve sets `done[resolve_id_i]`.
- Retire: `retire_v_o = live_r[head_r] & done_r[head_r]`. On retire, clear `live[head]` and advance head. At most one retire per cycle.
- Accepted mispredict with id X:
  - Younger tags are those from X+1 through tail-1 in ring order, possibly none. Each has its `live` and `done` bits cleared.
  - `tail <= X+1` with wrap; `done[X]` is set.
  - `flush_mask_r` takes the younger set and `flush_v_r` is set for one cycle.
  - X itself retires normally when it reaches head.
- Count next = count + grant − retire − popcount(younger). Implementations may instead recompute it from pointers; the result must be identical.
- Full and empty are based on registered count. A retire in the same cycle does not enable a grant when full.

## Timing
- Grant is combinational in the request cycle. The tag becomes live at the next edge, and `count_o` updates at that edge.
- Resolve at edge k makes `retire_v_o` visible in cycle k+1 if the tag is at head. Head advances at edge k+1.
- Mispredict at edge k: `flush_v_o` and `flush_mask_o` are valid in cycle k+1 only, then return to 0.
- Mispredict beats allocate in the same cycle: no grant, and tail follows the flush.
- Retire of head and mispredict of a different tag in the same cycle are both applied.
- Resolve of the tag being allocated in the same cycle is ignored, because it is not yet live.
- Reset asserted mid-operation clears all state immediately. There is no flush pulse and no retire.

## Test plan
- **Basic allocate:** reset, then hold `alloc_req_i` for 5 cycles → grants with IDs 0,1,2,3. The 5th request is denied, `full_o`=1, `count_o`=4.
- **Retire and wrap:** resolve ID 0 without mispredict → `retire_v_o`=1 with `retire_id_o`=0 the next cycle. `count_o` drops to 3, and the next grant gives ID 0.
- **Out-of-order resolve:** with IDs 0..3 live, resolve 2 then 1 then 0 → no retire until 0 is done. Then 0, 1, 2 retire on three consecutive cycles; 3 remains.
- **Mispredict squash:** with IDs 1,2,3,0 live (head=1), mispredict ID 2 → next cycle `flush_v_o`=1, `flush_mask_o`=4'b1001. `count_o`=2, and the next grant gives ID 3.
- **Simultaneous events:** `alloc_req_i` together with mispredict of head ID 0 → `alloc_gnt_o`=0, `flush_mask_o` covers all younger tags, `count_o`=1. Head retires the following cycle and `empty_o`=1.
- **Illegal resolve and reset:** resolve a non-live ID with mispredict → no state change and no flush. Assert `reset` while full → `empty_o`=1, `alloc_id_o`=0, and `flush_v_o` stays 0 in the same cycle.
